// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: stall/flush generation, E-stage
// operand forwarding, data-memory wait tracking and debug performance counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             we_reg_E,
  input  logic [1:0]       wb_ctrl_E,
  input  logic             redirect_E,
  input  logic [4:0]       rd_M,
  input  logic             we_reg_M,
  input  logic [4:0]       rd_W,
  input  logic             we_reg_W,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  input  logic             cnt_clr,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_memwait
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [15:0] WAIT_LIM = 16'(WAIT_LIMIT);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [15:0]      wait_inc;
  logic             mem_timeout_q, mem_timeout_d;
  logic             lu_q, lu_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [CNT_W-1:0] cnt_memwait_q, cnt_memwait_d;

  logic memstall;
  logic lu_hit;
  logic lu_take;
  logic redir_take;
  logic stall_fd;

  // Hazard priority: memory stall, then redirect, then load-use.
  always_comb begin
    memstall   = mem_req_M & ~mem_ready_M;
    lu_hit     = (wb_ctrl_E == 2'b01) && we_reg_E && (rd_E != 5'd0) &&
                 ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));
    redir_take = ~memstall & redirect_E;
    // A load-use bubble lasts one cycle; the flushed E slot cannot still hold the load.
    lu_take    = ~memstall & ~redirect_E & lu_hit & ~lu_q;
    stall_fd   = memstall | lu_take;
    lu_d       = lu_take;
  end

  always_comb begin
    stall_F = rst_n & stall_fd;
    stall_D = rst_n & stall_fd;
    stall_E = rst_n & memstall;
    stall_M = rst_n & memstall;
    flush_D = rst_n & redir_take;
    flush_E = rst_n & (redir_take | lu_take);
    flush_W = rst_n & memstall;
    fwd_a_E = rst_n ? fwd_sel(rs1_E, rd_M, we_reg_M, rd_W, we_reg_W) : 2'b00;
    fwd_b_E = rst_n ? fwd_sel(rs2_E, rd_M, we_reg_M, rd_W, we_reg_W) : 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    wait_inc      = (wait_cnt_q >= WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 16'd1;
    case (state_q)
      RUN: begin
        wait_cnt_d = 16'd0;
        if (memstall) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (wait_inc >= WAIT_LIM) begin
          mem_timeout_d = 1'b1;
        end
        // Leaving on ~memstall rather than mem_ready_M alone avoids hanging if the request is withdrawn.
        if (!memstall) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      default: state_d = RUN;
    endcase

    cnt_stall_d   = cnt_stall_q + {{(CNT_W-1){1'b0}}, stall_fd};
    cnt_flush_d   = cnt_flush_q + {{(CNT_W-1){1'b0}}, redir_take};
    cnt_memwait_d = cnt_memwait_q + {{(CNT_W-1){1'b0}}, (state_q == MEM_WAIT)};
    if (cnt_clr) begin
      cnt_stall_d   = '0;
      cnt_flush_d   = '0;
      cnt_memwait_d = '0;
      mem_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      lu_q          <= 1'b0;
      cnt_stall_q   <= '0;
      cnt_flush_q   <= '0;
      cnt_memwait_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      lu_q          <= lu_d;
      cnt_stall_q   <= cnt_stall_d;
      cnt_flush_q   <= cnt_flush_d;
      cnt_memwait_q <= cnt_memwait_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign cnt_stall   = cnt_stall_q;
  assign cnt_flush   = cnt_flush_q;
  assign cnt_memwait = cnt_memwait_q;

endmodule
